// File: rtl/simon_pkg.sv
// Shared definitions for the sequence player: FSM state encoding, default
// sizing constants and the phase-length helper.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_DONE
    } state_e;

    localparam int DEF_DEPTH       = 32;
    localparam int DEF_COLOUR_W    = 2;
    localparam int DEF_SPEED_W     = 3;
    localparam int DEF_BASE_CYCLES = 50_000_000;
    localparam int DEF_MIN_CYCLES  = 2;

    // Faster speeds halve the phase, but never below the floor.
    function automatic int unsigned phase_cycles(input int unsigned base,
                                                 input int unsigned min_cycles,
                                                 input int unsigned shift);
        int unsigned t;
        t = base >> shift;
        return (t < min_cycles) ? min_cycles : t;
    endfunction

endpackage

// File: rtl/sequence_player_phase_timer.sv
// Down-counter timing one ON or OFF phase: load a value, count to zero, hold.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Stores a list of colour codes and replays them oldest-first as timed
// one-hot LED flashes separated by equally long dark gaps.
module sequence_player
    import simon_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int COLOUR_W    = DEF_COLOUR_W,
    parameter int SPEED_W     = DEF_SPEED_W,
    parameter int BASE_CYCLES = DEF_BASE_CYCLES,
    parameter int MIN_CYCLES  = DEF_MIN_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         append_valid,
    input  logic [COLOUR_W-1:0]          append_colour,
    output logic                         append_ready,
    input  logic                         start,
    input  logic [SPEED_W-1:0]           speed,
    output logic                         busy,
    output logic                         done,
    output logic [(2**COLOUR_W)-1:0]     led,
    output logic [$clog2(DEPTH+1)-1:0]   length,
    output logic                         full
);

    localparam int NUM_COLOURS = 2**COLOUR_W;
    localparam int LEN_W       = $clog2(DEPTH+1);
    localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMAX        = (BASE_CYCLES > MIN_CYCLES) ? BASE_CYCLES : MIN_CYCLES;
    localparam int CNT_W       = (TMAX > 1) ? $clog2(TMAX) : 1;

    logic [COLOUR_W-1:0]    mem [DEPTH];

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [LEN_W-1:0]       length_q, length_d;
    logic [NUM_COLOURS-1:0] led_q, led_d;
    logic                   done_q, done_d;
    logic [SPEED_W-1:0]     speed_q, speed_d;

    logic                   append_fire;
    logic                   timer_load;
    logic                   timer_zero;
    logic                   last_elem;
    logic [IDX_W-1:0]       next_index;
    logic [COLOUR_W-1:0]    first_colour;
    logic [SPEED_W-1:0]     speed_src;
    logic [CNT_W-1:0]       reload_value;

    function automatic logic [NUM_COLOURS-1:0] onehot(input logic [COLOUR_W-1:0] c);
        logic [NUM_COLOURS-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    assign full         = (length_q == LEN_W'(DEPTH));
    assign append_ready = (state_q == ST_IDLE) && !full;
    assign append_fire  = append_valid && append_ready && !clear;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign led          = led_q;
    assign length       = length_q;

    assign next_index   = index_q + IDX_W'(1);
    assign last_elem    = (LEN_W'(index_q) == (length_q - LEN_W'(1)));
    // A colour appended in the same cycle as start is not yet in mem.
    assign first_colour = (length_q == '0) ? append_colour : mem[0];
    assign speed_src    = (state_q == ST_IDLE) ? speed : speed_q;
    assign reload_value = CNT_W'(phase_cycles(BASE_CYCLES, MIN_CYCLES, 32'(speed_src)) - 1);

    always_ff @(posedge clk) begin
        if (append_fire) begin
            mem[IDX_W'(length_q)] <= append_colour;
        end
    end

    always_comb begin
        length_d = length_q;
        if (clear) begin
            length_d = '0;
        end else if (append_fire) begin
            length_d = length_q + LEN_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        led_d      = led_q;
        done_d     = 1'b0;
        speed_d    = speed_q;
        timer_load = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            index_d = '0;
            led_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        speed_d    = speed;
                        timer_load = 1'b1;
                        index_d    = '0;
                        if ((length_q != '0) || append_fire) begin
                            state_d = ST_ON;
                            led_d   = onehot(first_colour);
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (timer_zero) begin
                        state_d    = ST_OFF;
                        led_d      = '0;
                        timer_load = 1'b1;
                    end
                end
                ST_OFF: begin
                    if (timer_zero) begin
                        if (last_elem) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = ST_ON;
                            index_d    = next_index;
                            led_d      = onehot(mem[next_index]);
                            timer_load = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            length_q <= '0;
            led_q    <= '0;
            done_q   <= 1'b0;
            speed_q  <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            length_q <= length_d;
            led_q    <= led_d;
            done_q   <= done_d;
            speed_q  <= speed_d;
        end
    end

    phase_timer #(
        .W(CNT_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (reload_value),
        .zero       (timer_zero)
    );

endmodule

// File: tb/tb_sequence_player.sv
// Randomised scoreboard bench for sequence_player: a timeline model predicts
// every flash (colour, width, preceding gap) and done pulse.
module tb_sequence_player;

    localparam int DEPTH    = 4;
    localparam int COLOUR_W = 2;
    localparam int SPEED_W  = 3;
    localparam int BASE     = 8;
    localparam int MINC     = 2;
    localparam int NEVER    = 32'h3fff_ffff;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                clear = 1'b0;
    logic                append_valid = 1'b0;
    logic [COLOUR_W-1:0] append_colour = '0;
    logic                start = 1'b0;
    logic [SPEED_W-1:0]  speed = '0;
    logic                append_ready;
    logic                busy;
    logic                done;
    logic [3:0]          led;
    logic [2:0]          length;
    logic                full;

    sequence_player #(
        .DEPTH       (DEPTH),
        .COLOUR_W    (COLOUR_W),
        .SPEED_W     (SPEED_W),
        .BASE_CYCLES (BASE),
        .MIN_CYCLES  (MINC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .append_valid  (append_valid),
        .append_colour (append_colour),
        .append_ready  (append_ready),
        .start         (start),
        .speed         (speed),
        .busy          (busy),
        .done          (done),
        .led           (led),
        .length        (length),
        .full          (full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int led;
        int len;
        int gap;
    } ev_t;

    ev_t exp_q[$];
    int  mdl[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int phase_len(input int s);
        int t;
        t = BASE >> s;
        return (t < MINC) ? MINC : t;
    endfunction

    // Monitor: turns the LED waveform and done pulses into events.
    int  prev_led = 0;
    int  run_len = 0;
    int  flash_gap = -1;
    ev_t mon_e;
    int  mon_gap;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) begin
                mon_gap = (led == 4'd0 && prev_led == 0) ? run_len : 0;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("event_is_done", 1, int'(mon_e.is_done));
                    if (mon_e.gap >= 0) checkOutput("done_gap", mon_gap, mon_e.gap);
                end
            end
            if (int'(led) != prev_led) begin
                if (prev_led != 0) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_flash", prev_led, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("event_is_flash", 0, int'(mon_e.is_done));
                        checkOutput("flash_led", prev_led, mon_e.led);
                        checkOutput("flash_len", run_len, mon_e.len);
                        if (mon_e.gap >= 0) checkOutput("flash_gap", flash_gap, mon_e.gap);
                    end
                end else begin
                    flash_gap = run_len;
                end
                prev_led = int'(led);
                run_len  = 1;
            end else begin
                run_len++;
            end
        end
    end

    task automatic applyStimulus(input bit clr, input bit av, input int col,
                                 input bit st, input int spd);
        clear         = clr;
        append_valid  = av;
        append_colour = COLOUR_W'(col);
        start         = st;
        speed         = SPEED_W'(spd);
        tick();
        clear        = 1'b0;
        append_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_length"}, int'(length), mdl.size());
        checkOutput({tag, "_full"}, int'(full), (mdl.size() == DEPTH) ? 1 : 0);
        checkOutput({tag, "_ready"}, int'(append_ready), (mdl.size() == DEPTH) ? 0 : 1);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_led"}, int'(led), 0);
    endtask

    task automatic appendColour(input int col);
        if (mdl.size() < DEPTH) mdl.push_back(col);
        applyStimulus(1'b0, 1'b1, col, 1'b0, 0);
        checkIdle("append");
    endtask

    task automatic clearAll(input bit with_append);
        mdl.delete();
        applyStimulus(1'b1, with_append, $urandom_range(0, 3), 1'b0, 0);
        checkIdle("clear");
    endtask

    // abort_off > 0: clear (or reset) sampled abort_off edges after start.
    task automatic playSequence(input int spd, input int abort_off, input bit by_reset,
                                input bit with_app, input int app_col);
        int t, n, k, a, d, s, e, len, off;
        ev_t ev;
        t = phase_len(spd);
        if (with_app && mdl.size() < DEPTH) mdl.push_back(app_col);
        n   = mdl.size();
        off = abort_off;
        if (n == 0) off = 0;
        if (off > 2 * n * t) off = 2 * n * t;
        clear         = 1'b0;
        speed         = SPEED_W'(spd);
        start         = 1'b1;
        append_valid  = with_app;
        append_colour = COLOUR_W'(app_col);
        tick();
        k = cyc;
        start        = 1'b0;
        append_valid = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
        a = (off > 0) ? k + off : NEVER;
        for (int i = 0; i < n; i++) begin
            s = k + 2 * i * t;
            e = s + t - 1;
            if (s <= a - 1) begin
                len = ((e < a - 1) ? e : a - 1) - s + 1;
                ev  = '{is_done: 1'b0, led: (1 << mdl[i]), len: len, gap: (i == 0) ? -1 : t};
                exp_q.push_back(ev);
            end
        end
        d = k + 2 * n * t;
        if (d <= a - 1) begin
            ev = '{is_done: 1'b1, led: 0, len: 0, gap: (n > 0) ? t : -1};
            exp_q.push_back(ev);
        end
        if (off > 0) begin
            while (cyc < a - 1) begin
                append_valid  = $urandom_range(0, 1);
                append_colour = COLOUR_W'($urandom_range(0, 3));
                start         = $urandom_range(0, 1);
                speed         = SPEED_W'($urandom_range(0, 7));
                tick();
            end
            append_valid = 1'b0;
            start        = 1'b0;
            if (by_reset) reset_n = 1'b0;
            else          clear   = 1'b1;
            tick();
            reset_n = 1'b1;
            clear   = 1'b0;
            mdl.delete();
            checkOutput("abort_done", int'(done), 0);
            checkIdle(by_reset ? "reset_abort" : "clear_abort");
            tick();
            checkOutput("abort_no_events", exp_q.size(), 0);
        end else begin
            while (cyc < d + 1) begin
                append_valid  = $urandom_range(0, 1);
                append_colour = COLOUR_W'($urandom_range(0, 3));
                start         = $urandom_range(0, 1);
                speed         = SPEED_W'($urandom_range(0, 7));
                tick();
            end
            append_valid = 1'b0;
            start        = 1'b0;
            for (int w = 0; w < 5 && exp_q.size() != 0; w++) tick();
            checkOutput("scoreboard_drained", exp_q.size(), 0);
            checkOutput("post_play_done", int'(done), 0);
            checkIdle("post_play");
        end
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, spd;
        reset_n = 1'b0;
        repeat (3) tick();
        checkOutput("reset_done", int'(done), 0);
        checkIdle("reset");
        reset_n = 1'b1;
        tick();
        mon_en = 1'b1;

        appendColour(2);
        appendColour(0);
        appendColour(3);
        playSequence(0, 0, 1'b0, 1'b0, 0);
        playSequence(2, 0, 1'b0, 1'b0, 0);
        playSequence(7, 0, 1'b0, 1'b0, 0);
        playSequence(1, 0, 1'b0, 1'b0, 0);

        clearAll(1'b0);
        for (int i = 0; i < 5; i++) appendColour(i % 4);

        clearAll(1'b0);
        playSequence(0, 0, 1'b0, 1'b0, 0);

        appendColour(1);
        appendColour(2);
        appendColour(3);
        playSequence(0, 2 * 8 + 2, 1'b0, 1'b0, 0);
        clearAll(1'b1);

        appendColour(3);
        appendColour(1);
        playSequence(0, 8 + 3, 1'b1, 1'b0, 0);
        appendColour(0);
        appendColour(2);
        playSequence(2, 0, 1'b0, 1'b0, 0);

        clearAll(1'b0);
        playSequence(1, 0, 1'b0, 1'b1, 3);
        playSequence(2, 0, 1'b0, 1'b1, 1);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) == 0) clearAll($urandom_range(0, 1));
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) appendColour($urandom_range(0, 3));
            spd = $urandom_range(0, 7);
            playSequence(spd, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 64) : 0,
                         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
